morse_decoder: RTL and testbench

//   Receive end of the Morse digit link: samples a serial key line, classifies

---
 rtl/morse_pkg.sv | 27 ++
 rtl/morse_tick_gen.sv | 23 ++
 rtl/morse_decoder.sv | 138 +++++++++++++
 tb/tb_morse_decoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared Morse digit link types, constants and digit pattern table
package morse_pkg;

    typedef enum logic [2:0] {IDLE, MARK, SPACE, DONE, HOLD} state_t;

    localparam logic SYM_DOT  = 1'b1;
    localparam logic SYM_DASH = 1'b0;
    localparam int   MORSE_LEN = 5;

    typedef struct packed {
        logic       hit;
        logic [3:0] digit;
    } lookup_t;

    // Patterns hold X1 in the MSB, so a left shift appends symbols in send order
    localparam logic [MORSE_LEN-1:0] DIGIT_PAT [10] = '{
        5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110,
        5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001
    };

    function automatic lookup_t digit_lookup(input logic [MORSE_LEN-1:0] pat);
        digit_lookup = '0;
        for (int i = 0; i < 10; i++)
            if (DIGIT_PAT[i] == pat) digit_lookup = '{hit: 1'b1, digit: 4'(i)};
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// morse_tick_gen: timing-tick prescaler that restarts from zero on every key edge
module morse_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else cnt <= (restart || cnt == LAST) ? '0 : cnt + W'(1);
    end

    assign tick = cnt == LAST;

endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: samples a Morse key line and decodes 5-symbol characters into digits 0-9
module morse_decoder
    import morse_pkg::*;
#(
    parameter int TICK_DIV  = 1000,
    parameter int DOT_MAX   = 2,
    parameter int DASH_MAX  = 6,
    parameter int GAP_TICKS = 3,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ready,
    input  logic       key,
    output logic       X1,
    output logic       X2,
    output logic       X3,
    output logic       X4,
    output logic       X5,
    output logic [3:0] digit,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    localparam logic [CNT_W-1:0] DOT_L  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] DASH_L = CNT_W'(DASH_MAX);
    localparam logic [CNT_W-1:0] GAP_L  = CNT_W'(GAP_TICKS - 1);
    localparam logic [2:0]       LEN    = 3'(MORSE_LEN);

    state_t               state, state_n;
    logic [1:0]           sync;
    logic                 ksync, kprev, tick;
    logic [CNT_W-1:0]     dur, dur_n, eff;
    logic [2:0]           n, n_n;
    logic [MORSE_LEN-1:0] sym, sym_n, pat;
    logic                 err_n, load;
    lookup_t              hit;

    assign ksync = sync[1];
    // A tick landing on the release cycle still belongs to the mark
    assign eff = dur + CNT_W'(tick);
    assign hit = digit_lookup(sym);
    assign {X1, X2, X3, X4, X5} = pat;

    morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk(clk),
        .reset_n(reset_n),
        .restart(ksync ^ kprev),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            kprev <= 1'b0;
        end else begin
            sync  <= {sync[0], key};
            kprev <= ksync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            dur   <= '0;
            n     <= '0;
            sym   <= '0;
            pat   <= '0;
            digit <= '0;
            valid <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            dur   <= dur_n;
            n     <= n_n;
            sym   <= sym_n;
            valid <= load;
            error <= err_n;
            if (load) begin
                pat   <= sym;
                digit <= hit.digit;
            end
        end
    end

    always_comb begin
        state_n = state;
        dur_n   = dur;
        n_n     = n;
        sym_n   = sym;
        err_n   = 1'b0;
        load    = 1'b0;
        if (!ready) begin
            state_n = IDLE;
            dur_n   = '0;
            n_n     = '0;
        end else begin
            case (state)
                IDLE: if (ksync) begin
                    state_n = MARK;
                    dur_n   = '0;
                    n_n     = '0;
                end
                MARK: if (tick && dur == DASH_L) begin
                    state_n = HOLD;
                    err_n   = 1'b1;
                end else if (!ksync) begin
                    dur_n = '0;
                    if (eff == '0) state_n = (n == '0) ? IDLE : SPACE;
                    else if (n == LEN) begin
                        state_n = HOLD;
                        err_n   = 1'b1;
                    end else begin
                        state_n = SPACE;
                        n_n     = n + 3'd1;
                        sym_n   = {sym[MORSE_LEN-2:0], (eff <= DOT_L) ? SYM_DOT : SYM_DASH};
                    end
                end else if (tick) dur_n = dur + CNT_W'(1);
                SPACE: if (tick && dur == GAP_L) begin
                    state_n = (n == LEN) ? DONE : IDLE;
                    load    = (n == LEN) && hit.hit;
                    err_n   = !load;
                    dur_n   = '0;
                end else if (ksync) begin
                    state_n = MARK;
                    dur_n   = '0;
                end else if (tick) dur_n = dur + CNT_W'(1);
                DONE: state_n = IDLE;
                HOLD: if (!ksync) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb busy = state != IDLE;

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: randomized key stimulus checked against a symbol-level decoder model
module tb_morse_decoder;

    localparam int TD = 4;

    logic       clk = 1'b0, reset_n = 1'b0, ready = 1'b0, key = 1'b0;
    logic       X1, X2, X3, X4, X5, valid, error, busy;
    logic [3:0] digit;
    logic [4:0] xs;

    typedef struct {
        bit         is_err;
        logic [3:0] d;
        logic [4:0] p;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    int         checks = 0, errors = 0, cyc = 0;
    int         nvalid = 0, nerror = 0, valid_cyc = 0, gap_cyc = 0;
    int         m_n = 0;
    logic [4:0] m_pat = '0, m_x = '0;
    logic [3:0] m_digit = '0;

    morse_decoder #(
        .TICK_DIV(TD), .DOT_MAX(2), .DASH_MAX(6), .GAP_TICKS(3), .CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ready(ready), .key(key),
        .X1(X1), .X2(X2), .X3(X3), .X4(X4), .X5(X5),
        .digit(digit), .valid(valid), .error(error), .busy(busy)
    );

    assign xs = {X1, X2, X3, X4, X5};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Digits 0-5 are d leading dots; 6-9 are (d-5) leading dashes then dots
    function automatic logic [4:0] pat_of(int d);
        return (d <= 5) ? 5'(31 << (5 - d)) : 5'(31 >> (d - 5));
    endfunction

    function automatic int digit_of(logic [4:0] p);
        for (int d = 0; d < 10; d++) if (pat_of(d) == p) return d;
        return -1;
    endfunction

    function automatic ev_t mk(bit e, logic [3:0] d, logic [4:0] p);
        ev_t r;
        r.is_err = e;
        r.d = d;
        r.p = p;
        return r;
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic step(int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: a mark of L cycles lasts L/TD whole ticks
    task automatic model_mark(int len);
        int t = len / TD;
        if (t == 0) return;
        if (t > 6 || m_n == 5) begin
            exp_q.push_back(mk(1'b1, 4'd0, 5'd0));
            m_n = 0;
        end else begin
            m_pat = {m_pat[3:0], 1'(t <= 2)};
            m_n++;
        end
    endtask

    task automatic model_gap();
        int d;
        if (m_n == 5) begin
            d = digit_of(m_pat);
            exp_q.push_back(mk(d < 0, 4'(d < 0 ? 0 : d), m_pat));
        end else if (m_n > 0) exp_q.push_back(mk(1'b1, 4'd0, 5'd0));
        m_n = 0;
    endtask

    task automatic mark(int len);
        model_mark(len);
        key = 1'b1;
        step(len);
        key = 1'b0;
    endtask

    task automatic gap(int len);
        gap_cyc = cyc;
        model_gap();
        step(len + 4);
        check("queue_drained", exp_q.size(), 0);
        check("idle_after_gap", int'(busy), 0);
    endtask

    // bits[5] is the first symbol; 1 = dot
    task automatic send(logic [5:0] bits, int cnt, bit jit);
        int t;
        for (int i = 0; i < cnt; i++) begin
            t = bits[5-i] ? (jit ? $urandom_range(1, 2) : 1) : (jit ? $urandom_range(3, 6) : 4);
            mark(TD * t + (jit ? $urandom_range(0, 3) : 0));
            if (i != cnt - 1) step(TD * (jit ? $urandom_range(1, 2) : 1) + (jit ? $urandom_range(0, 3) : 0));
        end
    endtask

    always @(negedge clk) begin
        if (valid || error) begin
            checks++;
            if (valid && error) begin
                errors++;
                $display("FAIL pulse_both: valid=%0d error=%0d required only one", valid, error);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: valid=%0d error=%0d required none", valid, error);
            end else begin
                ev = exp_q.pop_front();
                if (ev.is_err != error || (valid && (digit != ev.d || xs != ev.p))) begin
                    errors++;
                    $display("FAIL event: valid=%0d error=%0d digit=%0d X=%b required err=%0d digit=%0d X=%b",
                             valid, error, digit, xs, ev.is_err, ev.d, ev.p);
                end
                if (!ev.is_err) begin
                    m_x = ev.p;
                    m_digit = ev.d;
                end
            end
            if (valid) begin
                nvalid++;
                valid_cyc = cyc;
            end
            if (error) nerror++;
        end
        checks++;
        if (xs != m_x || digit != m_digit) begin
            errors++;
            $display("FAIL held_outputs: X=%b digit=%0d required X=%b digit=%0d", xs, digit, m_x, m_digit);
        end
    end

    initial begin
        int kind, cnt;
        logic [5:0] bits;
        step(3);
        reset_n = 1'b1;
        ready = 1'b1;
        step(2);
        check("reset_X", int'(xs), 0);
        check("reset_digit", int'(digit), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_error", int'(error), 0);
        check("reset_busy", int'(busy), 0);

        send(6'b000000, 5, 1'b0);
        gap(TD * 3);
        check("latency_gap_to_valid", valid_cyc - gap_cyc, 15);
        check("d0_count", nvalid, 1);
        check("d0_digit", int'(digit), 0);
        check("d0_X", int'(xs), 0);

        send(6'b111110, 5, 1'b0);
        gap(TD * 3);
        check("d5_digit", int'(digit), 5);
        check("d5_X", int'(xs), 5'b11111);

        send(6'b011110, 5, 1'b0);
        gap(TD * 3);
        check("d6_digit", int'(digit), 6);
        check("d6_X", int'(xs), 5'b01111);

        send(6'b101010, 5, 1'b0);
        gap(TD * 3);
        check("bad_pattern_err", nerror, 1);
        check("bad_pattern_digit_held", int'(digit), 6);

        send(6'b110000, 3, 1'b0);
        gap(TD * 3);
        check("short_char_err", nerror, 2);

        send(6'b111111, 6, 1'b0);
        step(6);
        check("six_symbols_err", nerror, 3);
        gap(TD * 3);
        check("six_symbols_no_more", nerror, 3);

        model_mark(TD * 8);
        key = 1'b1;
        step(TD * 8);
        check("stuck_key_err", nerror, 4);
        check("stuck_key_busy", int'(busy), 1);
        key = 1'b0;
        step(6);
        check("stuck_key_release", int'(busy), 0);
        model_mark(2);
        key = 1'b1;
        step(2);
        key = 1'b0;
        step(8);
        check("blip_ignored_busy", int'(busy), 0);
        check("blip_ignored_err", nerror, 4);

        send(6'b110000, 2, 1'b0);
        step(2);
        ready = 1'b0;
        m_n = 0;
        step(3);
        ready = 1'b1;
        gap(TD * 3);
        check("ready_drop_valid", nvalid, 3);
        check("ready_drop_err", nerror, 4);

        key = 1'b1;
        step(8);
        reset_n = 1'b0;
        exp_q.delete();
        m_n = 0;
        m_x = '0;
        m_digit = '0;
        #1;
        check("midreset_X", int'(xs), 0);
        check("midreset_digit", int'(digit), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_pulses", int'({valid, error}), 0);
        key = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(4);

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 99);
            if (kind < 65) begin
                send({pat_of($urandom_range(0, 9)), 1'b0}, 5, 1'b1);
            end else if (kind < 80) begin
                bits = 6'($urandom);
                send(bits, 5, 1'b1);
            end else if (kind < 92) begin
                bits = 6'($urandom);
                cnt = $urandom_range(1, 6);
                send(bits, cnt, 1'b1);
            end else begin
                bits = 6'($urandom);
                send(bits, $urandom_range(1, 3), 1'b1);
                step(TD * $urandom_range(1, 2));
                mark(TD * $urandom_range(7, 9) + $urandom_range(0, 3));
            end
            gap(TD * $urandom_range(3, 5) + $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
